rst_seq_ctl: RTL
================

# rst_seq_ctl

Parametrised reset sequencer for the mips789 system top: it replaces the fixed two-flop reset pipe feeding `mips_sys`. It synchronises an asynchronous board reset button and stretches every reset event to a minimum width. It releases `N_OUT` reset channels in staggered order (memory, core, peripherals) and adds software-requested and watchdog resets, with a sticky cause register.

## Interface
Parameters:
- `SYNC_STAGES`, 2, flops in the `ext_rst_i` synchroniser (≥2)
- `HOLD_CYCLES`, 16, minimum cycles all channels stay asserted after the last request clears (≥1)
- `N_OUT`, 3, number of reset channels (≥1)
- `STAGGER`, 4, cycles between successive channel releases (≥1)
- `WDT_TIMEOUT`, 65536, watchdog period in unpaused cycles; 0 disables the watchdog

Ports:
- `clk`  in  1  system clock; the only clock
- `rst`  in  1  master reset; synchronous, active-high
- `ext_rst_i`  in  1  board reset button, asynchronous, active-high level
- `sw_rst_req`  in  1  single-cycle software reset request from the core
- `wdt_kick`  in  1  watchdog service pulse
- `pause`  in  1  system pause; freezes the watchdog only
- `rst_o`  out  N_OUT  per-channel resets, active-high; bit 0 released first
- `busy_o`  out  1  high while any channel is asserted
- `rst_cause_o`  out  3  sticky cause bits: [0] ext, [1] sw, [2] wdt

## Operation
- States: HOLD, RELEASE, RUN.
- `rst`=1 (highest priority):
  - state←HOLD; hold counter←0; synchroniser chain←0; watchdog←0.
  - Outputs: `rst_o`=all ones, `busy_o`=1, `rst_cause_o`=0.
- `ext_s` is the last stage of the synchroniser chain. A request is `ext_s`, `sw_rst_req`, or a watchdog expiry.
- HOLD:
  - `ext_s`=1: hold counter held at 0 (stretch for as long as the button is held).
  - `sw_rst_req`=1: hold counter←0.
  - Otherwise the counter increments. On the edge where it reaches HOLD_CYCLES: state←RELEASE, `rst_o[0]`←0, stagger counter←0, channel index←1.
- RELEASE:
  - The stagger counter increments every cycle.
  - On reaching STAGGER it clears, `rst_o[index]`←0, and index increments.
  - The edge that clears bit N_OUT-1 also sets state←RUN and `busy_o`←0. With N_OUT=1, HOLD goes directly to RUN on the bit-0 edge.
- RUN:
  - If WDT_TIMEOUT≠0, the watchdog increments when `pause`=0.
  - `wdt_kick`=1 clears the watchdog to 0, regardless of `pause`. A kick has priority over expiry in the same cycle.
  - The edge on which the counter would reach WDT_TIMEOUT is an expiry.
  - The watchdog stays at 0 outside RUN.
- Any request in RELEASE or RUN, on the same edge:
  - `rst_o`←all ones, `busy_o`←1, state←HOLD, hold counter←0.
  - Already-released channels re-assert.
- Cause bits OR-accumulate for every request seen in any state. Simultaneous requests set all matching bits. Only `rst` clears them.
- `pause` has no effect on HOLD or RELEASE.
- Widths: hold counter $clog2(HOLD_CYCLES+1); stagger counter $clog2(STAGGER+1); watchdog $clog2(WDT_TIMEOUT+1). No wrap is reachable.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Edges are numbered from edge 1, the first edge sampling `rst`=0.
  - `rst_o[k]` falls at edge HOLD_CYCLES + k·STAGGER.
  - `busy_o` falls at edge HOLD_CYCLES + (N_OUT-1)·STAGGER.
  - Defaults: edges 16, 20, 24.
- `sw_rst_req` sampled high at edge n → `rst_o` all ones after edge n.
- `ext_rst_i` rising → `rst_o` all ones within SYNC_STAGES+1 edges.
- `ext_rst_i` falling → `ext_s` low SYNC_STAGES edges later; release then proceeds per the release timing above, counted from that point.
- Watchdog expiry: RUN entered at edge E with no kicks or pauses → `rst_o` all ones at edge E+WDT_TIMEOUT. Each paused cycle adds one cycle to that.

## Test plan
- Power-up with defaults: `rst` high for 3 cycles, then low → `rst_o` 111→110@16→100@20→000@24; `busy_o` falls @24; `rst_cause_o`=000.
- `sw_rst_req` pulse 10 cycles into RUN → `rst_o`=111 next edge; `rst_cause_o`=010; release again 16/20/24 edges later.
- `ext_rst_i` asserted asynchronously for 40 cycles in RUN → `rst_o`=111 within 3 edges and stays 111 while held. After release, bit 0 falls 2+16 edges after the input falls; `rst_cause_o`=001.
- WDT_TIMEOUT=32, no kicks → expiry 32 edges after RUN entry, cause=100. With a kick every 20 cycles → no reset for 1000 cycles. With `pause` high for 10 cycles → expiry delayed by 10.
- `sw_rst_req` between the release of bit 0 and bit 1 → all bits return to 111 on that edge; the full HOLD_CYCLES restarts.
- `sw_rst_req` and watchdog expiry on the same edge → cause=110; `rst` then clears cause to 000.

Source files
------------

// File: rtl/rst_seq_ctl.sv
// Reset sequencer for the mips789 system top.
// Synchronises the board reset button, stretches every reset event to a
// minimum width, releases the reset channels one after another and adds
// software and watchdog reset sources with a sticky cause register.
module rst_seq_ctl #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int N_OUT       = 3,
    parameter int STAGGER     = 4,
    parameter int WDT_TIMEOUT = 65536
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ext_rst_i,
    input  logic             sw_rst_req,
    input  logic             wdt_kick,
    input  logic             pause,
    output logic [N_OUT-1:0] rst_o,
    output logic             busy_o,
    output logic [2:0]       rst_cause_o
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int STG_W  = $clog2(STAGGER + 1);
    localparam int IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int WDT_W  = (WDT_TIMEOUT > 0) ? $clog2(WDT_TIMEOUT + 1) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);
    localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGGER);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_OUT - 1);
    localparam logic [IDX_W-1:0]  IDX_FIRST = IDX_W'(1);
    localparam logic [WDT_W-1:0]  WDT_LAST  = WDT_W'(WDT_TIMEOUT);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [STG_W-1:0]       stg_q, stg_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [WDT_W-1:0]       wdt_q, wdt_d;
    logic [N_OUT-1:0]       rst_q, rst_d;
    logic                   busy_q, busy_d;
    logic [2:0]             cause_q, cause_d;

    logic                   ext_s;
    logic                   wdt_exp;
    logic                   req;
    logic [HOLD_W-1:0]      hold_inc;
    logic [STG_W-1:0]       stg_inc;

    // Next-state logic: request detection, hold/stagger sequencing and watchdog.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], ext_rst_i};
        ext_s    = sync_q[SYNC_STAGES-1];
        hold_inc = hold_q + 1'b1;
        stg_inc  = stg_q + 1'b1;

        wdt_exp = 1'b0;
        if ((WDT_TIMEOUT != 0) && (state_q == ST_RUN) && !wdt_kick && !pause
            && ((wdt_q + 1'b1) == WDT_LAST)) begin
            wdt_exp = 1'b1;
        end

        req     = ext_s | sw_rst_req | wdt_exp;
        cause_d = cause_q | {wdt_exp, sw_rst_req, ext_s};

        state_d = state_q;
        hold_d  = hold_q;
        stg_d   = stg_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        busy_d  = busy_q;
        wdt_d   = '0;

        case (state_q)
            ST_HOLD: begin
                if (ext_s || sw_rst_req) begin
                    hold_d = '0;
                end else begin
                    hold_d = hold_inc;
                    if (hold_inc == HOLD_LAST) begin
                        rst_d[0] = 1'b0;
                        stg_d    = '0;
                        idx_d    = IDX_FIRST;
                        if (N_OUT == 1) begin
                            state_d = ST_RUN;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end
                end
            end
            ST_RELEASE: begin
                if (stg_inc == STG_LAST) begin
                    stg_d = '0;
                    for (int i = 0; i < N_OUT; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            rst_d[i] = 1'b0;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    stg_d = stg_inc;
                end
            end
            ST_RUN: begin
                if (WDT_TIMEOUT != 0) begin
                    if (wdt_kick) begin
                        wdt_d = '0;
                    end else if (pause) begin
                        wdt_d = wdt_q;
                    end else begin
                        wdt_d = wdt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase

        if (req && (state_q != ST_HOLD)) begin
            rst_d   = '1;
            busy_d  = 1'b1;
            state_d = ST_HOLD;
            hold_d  = '0;
            wdt_d   = '0;
        end
    end

    // State and output registers; master reset forces every channel asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HOLD;
            sync_q  <= '0;
            hold_q  <= '0;
            stg_q   <= '0;
            idx_q   <= '0;
            wdt_q   <= '0;
            rst_q   <= '1;
            busy_q  <= 1'b1;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            hold_q  <= hold_d;
            stg_q   <= stg_d;
            idx_q   <= idx_d;
            wdt_q   <= wdt_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
            cause_q <= cause_d;
        end
    end

    assign rst_o       = rst_q;
    assign busy_o      = busy_q;
    assign rst_cause_o = cause_q;

endmodule
